// File: rtl/s_axi_lite_regs_if.sv
// AXI4-Lite bus bundle between an initiator (master) and the register bank (slave).
interface s_axi_lite_regs_if #(
   parameter int unsigned DWIDTH = 32
) ();
   logic                  awvalid;
   logic [DWIDTH-1:0]     awaddr;
   logic [2:0]            awprot;
   logic                  awready;
   logic                  wvalid;
   logic [DWIDTH-1:0]     wdata;
   logic [DWIDTH/8-1:0]   wstrb;
   logic                  wready;
   logic                  bvalid;
   logic [1:0]            bresp;
   logic                  bready;
   logic                  arvalid;
   logic [DWIDTH-1:0]     araddr;
   logic [2:0]            arprot;
   logic                  arready;
   logic                  rvalid;
   logic [DWIDTH-1:0]     rdata;
   logic [1:0]            rresp;
   logic                  rready;

   modport master (
      output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
      output arvalid, araddr, arprot, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slave (
      input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
      input  arvalid, araddr, arprot, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/s_axi_lite_regs.sv
// AXI4-Lite responder with NREG byte-strobed 32-bit registers, a register-0 probe
// and sticky {rd_err, wr_err} flags.
module s_axi_lite_regs #(
   parameter int unsigned DWIDTH  = 32,
   parameter int unsigned NREG    = 16,
   parameter logic [31:0] BASE    = 32'h0,
   parameter int unsigned IDX_BIT = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              xrst,
   s_axi_lite_regs_if.slave  bus,
   output logic [DWIDTH-1:0] probe,
   output logic [1:0]        err
);
   localparam logic [DWIDTH-1:0] SPAN        = DWIDTH'(4 * NREG);
   localparam logic [1:0]        RESP_OKAY   = 2'b00;
   localparam logic [1:0]        RESP_SLVERR = 2'b10;

   typedef logic [DWIDTH-1:0] word_t;

   word_t               regs_q [NREG];
   word_t               regs_d [NREG];
   word_t               probe_q;
   logic [1:0]          err_q, err_d;

   logic                aw_full_q, aw_full_d;
   word_t               aw_addr_q, aw_addr_d;
   logic                w_full_q, w_full_d;
   word_t               w_data_q, w_data_d;
   logic [DWIDTH/8-1:0] w_strb_q, w_strb_d;
   logic                awready_q, awready_d;
   logic                wready_q, wready_d;
   logic                bvalid_q, bvalid_d;
   logic [1:0]          bresp_q, bresp_d;

   logic                ar_full_q, ar_full_d;
   word_t               ar_addr_q, ar_addr_d;
   logic                arready_q, arready_d;
   logic                rvalid_q, rvalid_d;
   word_t               rdata_q, rdata_d;
   logic [1:0]          rresp_q, rresp_d;

   // Extra top bit catches addresses below BASE as a borrow.
   logic [DWIDTH:0]     aw_diff, ar_diff;
   logic                aw_hit, ar_hit;
   logic [IDX_BIT-1:0]  aw_idx, ar_idx;

   logic                unused_prot;
   assign unused_prot = ^{bus.awprot, bus.arprot};

   assign aw_diff = {1'b0, aw_addr_q} - {1'b0, BASE};
   assign ar_diff = {1'b0, ar_addr_q} - {1'b0, BASE};
   assign aw_hit  = !aw_diff[DWIDTH] && (aw_diff[DWIDTH-1:0] < SPAN) && (aw_addr_q[1:0] == 2'b00);
   assign ar_hit  = !ar_diff[DWIDTH] && (ar_diff[DWIDTH-1:0] < SPAN) && (ar_addr_q[1:0] == 2'b00);
   assign aw_idx  = aw_diff[IDX_BIT+1:2];
   assign ar_idx  = ar_diff[IDX_BIT+1:2];

   always_comb begin
      regs_d    = regs_q;
      err_d     = err_q;
      aw_full_d = aw_full_q;
      aw_addr_d = aw_addr_q;
      w_full_d  = w_full_q;
      w_data_d  = w_data_q;
      w_strb_d  = w_strb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      ar_full_d = ar_full_q;
      ar_addr_d = ar_addr_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;

      // Write path: capture slots fill independently, commit once both are full.
      if (bvalid_q && bus.bready) begin
         bvalid_d = 1'b0;
      end
      if (aw_full_q && w_full_q && !bvalid_q) begin
         aw_full_d = 1'b0;
         w_full_d  = 1'b0;
         bvalid_d  = 1'b1;
         if (aw_hit) begin
            bresp_d = RESP_OKAY;
            for (int k = 0; k < DWIDTH / 8; k++) begin
               if (w_strb_q[k]) begin
                  regs_d[aw_idx][8*k +: 8] = w_data_q[8*k +: 8];
               end
            end
         end else begin
            bresp_d  = RESP_SLVERR;
            err_d[0] = 1'b1;
         end
      end
      if (bus.awvalid && awready_q) begin
         aw_full_d = 1'b1;
         aw_addr_d = bus.awaddr;
      end
      if (bus.wvalid && wready_q) begin
         w_full_d = 1'b1;
         w_data_d = bus.wdata;
         w_strb_d = bus.wstrb;
      end

      // Read path: sample the register array one edge after the address is held,
      // so a same-edge write commit is not yet visible.
      if (rvalid_q && bus.rready) begin
         rvalid_d = 1'b0;
      end
      if (ar_full_q) begin
         ar_full_d = 1'b0;
         rvalid_d  = 1'b1;
         if (ar_hit) begin
            rdata_d = regs_q[ar_idx];
            rresp_d = RESP_OKAY;
         end else begin
            rdata_d  = '0;
            rresp_d  = RESP_SLVERR;
            err_d[1] = 1'b1;
         end
      end else if (bus.arvalid && arready_q) begin
         ar_full_d = 1'b1;
         ar_addr_d = bus.araddr;
      end

      awready_d = !aw_full_d && !bvalid_d;
      wready_d  = !w_full_d && !bvalid_d;
      arready_d = !ar_full_d && !rvalid_d;
   end

   always_ff @(posedge clk) begin
      if (xrst) begin
         regs_q    <= '{default: '0};
         probe_q   <= '0;
         err_q     <= '0;
         aw_full_q <= 1'b0;
         aw_addr_q <= '0;
         w_full_q  <= 1'b0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= '0;
         ar_full_q <= 1'b0;
         ar_addr_q <= '0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= '0;
      end else begin
         regs_q    <= regs_d;
         probe_q   <= regs_q[0];
         err_q     <= err_d;
         aw_full_q <= aw_full_d;
         aw_addr_q <= aw_addr_d;
         w_full_q  <= w_full_d;
         w_data_q  <= w_data_d;
         w_strb_q  <= w_strb_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         ar_full_q <= ar_full_d;
         ar_addr_q <= ar_addr_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

   assign bus.awready = awready_q;
   assign bus.wready  = wready_q;
   assign bus.bvalid  = bvalid_q;
   assign bus.bresp   = bresp_q;
   assign bus.arready = arready_q;
   assign bus.rvalid  = rvalid_q;
   assign bus.rdata   = rdata_q;
   assign bus.rresp   = rresp_q;
   assign probe       = probe_q;
   assign err         = err_q;

endmodule

// File: tb/tb_s_axi_lite_regs.sv
// Self-checking bench for s_axi_lite_regs: directed scenarios plus randomized traffic
// compared against an array model of the register bank.
module tb_s_axi_lite_regs;
   localparam int          NREG = 16;
   localparam logic [31:0] BASE = 32'h0000_1000;
   localparam int          TMO  = 30;

   logic        clk = 1'b0;
   logic        xrst = 1'b1;
   logic [31:0] probe;
   logic [1:0]  err;

   int checks = 0;
   int errors = 0;

   logic [31:0] model [NREG];
   logic [1:0]  model_err;

   s_axi_lite_regs_if #(.DWIDTH(32)) bus ();

   s_axi_lite_regs #(
      .DWIDTH(32),
      .NREG  (NREG),
      .BASE  (BASE)
   ) dut (
      .clk  (clk),
      .xrst (xrst),
      .bus  (bus),
      .probe(probe),
      .err  (err)
   );

   always #5 clk = ~clk;

   function automatic bit is_hit(input logic [31:0] a);
      longint unsigned la = a;
      longint unsigned lb = BASE;
      return (la >= lb) && (la < lb + 4 * NREG) && ((a % 4) == 0);
   endfunction

   function automatic int idx_of(input logic [31:0] a);
      return int'((a - BASE) / 4);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                         input logic [3:0] strb);
      logic [31:0] res = old;
      for (int k = 0; k < 4; k++) begin
         if (strb[k]) res[8*k +: 8] = data[8*k +: 8];
      end
      return res;
   endfunction

   // Every task starts and ends 1 time unit after a rising edge.
   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly,
                            output logic [1:0] resp);
      int n = 0;
      bit aw_done = 0, w_done = 0, aw_hs, w_hs;
      bus.awaddr = addr;
      bus.wdata  = data;
      bus.wstrb  = strb;
      bus.bready = 1'b1;
      while (!(aw_done && w_done) && n < TMO) begin
         bus.awvalid = !aw_done && (n >= aw_dly);
         bus.wvalid  = !w_done && (n >= w_dly);
         aw_hs = bus.awvalid && bus.awready;
         w_hs  = bus.wvalid && bus.wready;
         @(posedge clk); #1; n++;
         if (aw_hs) aw_done = 1;
         if (w_hs) w_done = 1;
      end
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      while (!bus.bvalid && n < TMO) begin
         @(posedge clk); #1; n++;
      end
      resp = bus.bresp;
      @(posedge clk); #1;
      checks++;
      if (n >= TMO) begin
         errors++;
         $display("FAIL write_timeout addr=%h: got %0d cycles, required < %0d", addr, n, TMO);
      end
   endtask

   task automatic axi_read(input logic [31:0] addr, input int dly,
                           output logic [31:0] data, output logic [1:0] resp);
      int n = 0;
      bit done = 0, hs;
      bus.araddr = addr;
      bus.rready = 1'b1;
      while (!done && n < TMO) begin
         bus.arvalid = (n >= dly);
         hs = bus.arvalid && bus.arready;
         @(posedge clk); #1; n++;
         if (hs) done = 1;
      end
      bus.arvalid = 1'b0;
      while (!bus.rvalid && n < TMO) begin
         @(posedge clk); #1; n++;
      end
      data = bus.rdata;
      resp = bus.rresp;
      @(posedge clk); #1;
      checks++;
      if (n >= TMO) begin
         errors++;
         $display("FAIL read_timeout addr=%h: got %0d cycles, required < %0d", addr, n, TMO);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b0) begin
         errors++;
         $display("FAIL reset_handshake: got %b required 00000",
                  {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid});
      end
      checks++;
      if ({bus.bresp, bus.rresp, bus.rdata, err, probe} !== '0) begin
         errors++;
         $display("FAIL reset_data: bresp=%b rresp=%b rdata=%h err=%b probe=%h required all 0",
                  bus.bresp, bus.rresp, bus.rdata, err, probe);
      end
      xrst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
         errors++;
         $display("FAIL reset_release_ready: got %b required 111",
                  {bus.awready, bus.wready, bus.arready});
      end
   endtask

   task automatic test_same_cycle();
      logic [31:0] d = 32'h1234_5678, got;
      logic [1:0]  resp;
      bus.awaddr = BASE + 32'h4; bus.wdata = d; bus.wstrb = 4'hF; bus.bready = 1'b1;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      @(posedge clk); #1;
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      checks++;
      if ({bus.awready, bus.wready, bus.bvalid} !== 3'b000) begin
         errors++;
         $display("FAIL same_cycle_capture: aw/w/b got %b required 000",
                  {bus.awready, bus.wready, bus.bvalid});
      end
      @(posedge clk); #1;
      checks++;
      if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00) begin
         errors++;
         $display("FAIL same_cycle_bresp: bvalid=%b bresp=%b required 1 00", bus.bvalid, bus.bresp);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.bvalid !== 1'b0 || bus.awready !== 1'b1 || bus.wready !== 1'b1) begin
         errors++;
         $display("FAIL same_cycle_bhs: bvalid=%b awready=%b wready=%b required 0 1 1",
                  bus.bvalid, bus.awready, bus.wready);
      end
      model[1] = d;
      axi_read(BASE + 32'h4, 0, got, resp);
      checks++;
      if (got !== model[1] || resp !== 2'b00) begin
         errors++;
         $display("FAIL same_cycle_read: got %h/%b required %h/00", got, resp, model[1]);
      end
   endtask

   task automatic test_w_before_aw();
      logic [31:0] got;
      logic [1:0]  resp;
      axi_write(BASE + 32'h8, 32'h1111_1111, 4'hF, 0, 0, resp);
      model[2] = 32'h1111_1111;
      bus.wdata = 32'hAABB_CCDD; bus.wstrb = 4'b0101; bus.wvalid = 1'b1; bus.bready = 1'b1;
      @(posedge clk); #1;
      bus.wvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (bus.bvalid !== 1'b0 || bus.wready !== 1'b0) begin
            errors++;
            $display("FAIL w_first_wait%0d: bvalid=%b wready=%b required 0 0",
                     i, bus.bvalid, bus.wready);
         end
         @(posedge clk); #1;
      end
      bus.awaddr = BASE + 32'h8; bus.awvalid = 1'b1;
      @(posedge clk); #1;
      bus.awvalid = 1'b0;
      checks++;
      if (bus.bvalid !== 1'b0) begin
         errors++;
         $display("FAIL w_first_aw_capture: bvalid=%b required 0", bus.bvalid);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00) begin
         errors++;
         $display("FAIL w_first_bresp: bvalid=%b bresp=%b required 1 00", bus.bvalid, bus.bresp);
      end
      @(posedge clk); #1;
      model[2] = merge(model[2], 32'hAABB_CCDD, 4'b0101);
      axi_read(BASE + 32'h8, 0, got, resp);
      checks++;
      if (got !== model[2] || got !== 32'h11BB_11DD) begin
         errors++;
         $display("FAIL w_first_strobe: got %h required %h", got, model[2]);
      end
   endtask

   task automatic test_errors();
      logic [31:0] got, d = $urandom;
      logic [1:0]  resp;
      axi_write(BASE, d, 4'hF, 0, 0, resp);
      model[0] = d;
      axi_write(BASE + 4 * NREG, ~d, 4'hF, 0, 0, resp);
      checks++;
      if (resp !== 2'b10) begin
         errors++;
         $display("FAIL err_write_range: bresp=%b required 10", resp);
      end
      axi_write(BASE + 32'h2, ~d, 4'hF, 1, 0, resp);
      checks++;
      if (resp !== 2'b10 || err !== 2'b01) begin
         errors++;
         $display("FAIL err_write_align: bresp=%b err=%b required 10 01", resp, err);
      end
      model_err = 2'b01;
      axi_read(BASE, 0, got, resp);
      checks++;
      if (got !== model[0] || probe !== model[0]) begin
         errors++;
         $display("FAIL err_no_write: reg0=%h probe=%h required %h", got, probe, model[0]);
      end
      axi_read(BASE + 32'h40, 0, got, resp);
      model_err = 2'b11;
      checks++;
      if (got !== 32'h0 || resp !== 2'b10 || err !== model_err) begin
         errors++;
         $display("FAIL err_read_range: rdata=%h rresp=%b err=%b required 0 10 11", got, resp, err);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] d1 = $urandom, d2 = $urandom, got;
      logic [1:0]  resp;
      bus.bready = 1'b0;
      bus.awaddr = BASE + 4 * 5; bus.wdata = d1; bus.wstrb = 4'hF;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      @(posedge clk); #1;
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      @(posedge clk); #1;
      model[5] = d1;
      bus.awaddr = BASE + 4 * 6; bus.wdata = d2; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({bus.bvalid, bus.bresp, bus.awready, bus.wready} !== 5'b10000) begin
            errors++;
            $display("FAIL bp_hold%0d: bvalid,bresp,awready,wready got %b required 10000",
                     i, {bus.bvalid, bus.bresp, bus.awready, bus.wready});
         end
         @(posedge clk); #1;
      end
      bus.bready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({bus.bvalid, bus.awready, bus.wready} !== 3'b011) begin
         errors++;
         $display("FAIL bp_release: bvalid,awready,wready got %b required 011",
                  {bus.bvalid, bus.awready, bus.wready});
      end
      @(posedge clk); #1;
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00) begin
         errors++;
         $display("FAIL bp_second_b: bvalid=%b bresp=%b required 1 00", bus.bvalid, bus.bresp);
      end
      model[6] = d2;
      @(posedge clk); #1;
      for (int r = 5; r <= 6; r++) begin
         axi_read(BASE + 32'(4 * r), 0, got, resp);
         checks++;
         if (got !== model[r]) begin
            errors++;
            $display("FAIL bp_readback%0d: got %h required %h", r, got, model[r]);
         end
      end
   endtask

   task automatic test_collision();
      logic [31:0] got;
      logic [1:0]  resp;
      axi_write(BASE + 32'hC, 32'h5, 4'hF, 0, 0, resp);
      model[3] = 32'h5;
      bus.araddr = BASE + 32'hC; bus.awaddr = BASE + 32'hC; bus.wdata = 32'h9; bus.wstrb = 4'hF;
      bus.rready = 1'b1; bus.bready = 1'b1;
      bus.arvalid = 1'b1; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      @(posedge clk); #1;
      bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (bus.rvalid !== 1'b1 || bus.bvalid !== 1'b1 || bus.rdata !== model[3]) begin
         errors++;
         $display("FAIL collision_old: rvalid=%b bvalid=%b rdata=%h required 1 1 %h",
                  bus.rvalid, bus.bvalid, bus.rdata, model[3]);
      end
      @(posedge clk); #1;
      model[3] = 32'h9;
      axi_read(BASE + 32'hC, 0, got, resp);
      checks++;
      if (got !== model[3]) begin
         errors++;
         $display("FAIL collision_new: got %h required %h", got, model[3]);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 60; i++) begin
         logic [31:0] addr, data, got, exp;
         logic [3:0]  strb;
         logic [1:0]  resp;
         int          idx;
         idx = int'($urandom_range(NREG - 1));
         case ($urandom_range(5))
            0:       addr = BASE + 32'(4 * NREG) + 32'(4 * $urandom_range(15));
            1:       addr = BASE + 32'(4 * idx) + 32'($urandom_range(3, 1));
            2:       addr = BASE - 32'(4 * $urandom_range(8, 1));
            default: addr = BASE + 32'(4 * idx);
         endcase
         if ($urandom_range(1) == 1) begin
            data = $urandom;
            strb = 4'($urandom_range(15));
            axi_write(addr, data, strb, int'($urandom_range(3)), int'($urandom_range(3)), resp);
            if (is_hit(addr)) model[idx_of(addr)] = merge(model[idx_of(addr)], data, strb);
            else model_err[0] = 1'b1;
            checks++;
            if (resp !== (is_hit(addr) ? 2'b00 : 2'b10)) begin
               errors++;
               $display("FAIL rand_bresp%0d addr=%h: got %b", i, addr, resp);
            end
         end else begin
            axi_read(addr, int'($urandom_range(3)), got, resp);
            exp = is_hit(addr) ? model[idx_of(addr)] : 32'h0;
            if (!is_hit(addr)) model_err[1] = 1'b1;
            checks++;
            if (got !== exp || resp !== (is_hit(addr) ? 2'b00 : 2'b10)) begin
               errors++;
               $display("FAIL rand_read%0d addr=%h: got %h/%b required %h", i, addr, got, resp, exp);
            end
         end
         checks++;
         if (err !== model_err || probe !== model[0]) begin
            errors++;
            $display("FAIL rand_status%0d: err=%b probe=%h required %b %h",
                     i, err, probe, model_err, model[0]);
         end
      end
   endtask

   task automatic test_reset_midread();
      logic [31:0] got, d = $urandom | 32'h1;
      logic [1:0]  resp;
      axi_write(BASE, d, 4'hF, 0, 0, resp);
      model[0] = d;
      bus.araddr = BASE; bus.rready = 1'b0; bus.arvalid = 1'b1;
      @(posedge clk); #1;
      bus.arvalid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (bus.rvalid !== 1'b1 || bus.rdata !== d) begin
         errors++;
         $display("FAIL midread_pending: rvalid=%b rdata=%h required 1 %h", bus.rvalid, bus.rdata, d);
      end
      xrst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus.rvalid !== 1'b0 || err !== 2'b00 || probe !== 32'h0 || bus.arready !== 1'b0) begin
         errors++;
         $display("FAIL midread_reset: rvalid=%b err=%b probe=%h arready=%b required 0 00 0 0",
                  bus.rvalid, err, probe, bus.arready);
      end
      xrst = 1'b0;
      bus.rready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus.arready !== 1'b1) begin
         errors++;
         $display("FAIL midread_arready: got %b required 1", bus.arready);
      end
      for (int r = 0; r < NREG; r++) model[r] = '0;
      model_err = 2'b00;
      for (int r = 0; r < NREG; r++) begin
         axi_read(BASE + 32'(4 * r), 0, got, resp);
         checks++;
         if (got !== model[r] || resp !== 2'b00) begin
            errors++;
            $display("FAIL midread_cleared%0d: got %h/%b required 0/00", r, got, resp);
         end
      end
   endtask

   initial begin
      bus.awvalid = 1'b0; bus.awaddr = '0; bus.awprot = '0;
      bus.wvalid  = 1'b0; bus.wdata  = '0; bus.wstrb  = '0; bus.bready = 1'b0;
      bus.arvalid = 1'b0; bus.araddr = '0; bus.arprot = '0; bus.rready = 1'b0;
      for (int r = 0; r < NREG; r++) model[r] = '0;
      model_err = 2'b00;
      test_reset();
      test_same_cycle();
      test_w_before_aw();
      test_errors();
      test_backpressure();
      test_collision();
      test_random();
      test_reset_midread();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
